// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO.
package axis_pkt_fifo_pkg;

    // Write-side packet FSM states (only advance when PACKET_MODE != 0)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

    // Address width for a power-of-two depth
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module axis_pkt_fifo_ram #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Entry write on accepted beat
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with backpressure, tkeep, occupancy flags and optional
// store-and-forward packet mode that discards packets larger than the FIFO.
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned PACKET_MODE = 0,
    parameter int unsigned AF_LEVEL    = 12,
    parameter int unsigned AE_LEVEL    = 2,
    localparam int unsigned KEEP_W     = DATA_W / 8,
    localparam int unsigned AW         = ptr_w(DEPTH)
) (
    input  logic              axis_clk,
    input  logic              reset,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [AW:0]       count,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              drop_pkt
);

    localparam int unsigned ENT_W = DATA_W + KEEP_W + 1;

    typedef logic [AW:0] ptr_t;

    localparam ptr_t AF_LVL  = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_LVL  = ptr_t'(AE_LEVEL);
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t ONE_P   = ptr_t'(1);

    ptr_t             wr_ptr, cm_ptr, rd_ptr;
    ptr_t             wr_nxt, cm_nxt, rd_nxt, cnt_nxt, fill_after;
    wr_state_e        state;
    logic             wr_en, rd_en, go_drop, full_nxt, bypass;
    logic [ENT_W-1:0] wr_ent, ram_rd, head_nxt;

    assign wr_ent = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};

    axis_pkt_fifo_ram #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (axis_clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_ent),
        .raddr (rd_nxt[AW-1:0]),
        .rdata (ram_rd)
    );

    // Next pointer values, drop decision and next head entry
    always_comb begin
        wr_en      = s_axis_tvalid && s_axis_tready && (state != ST_DROP);
        rd_en      = m_axis_tvalid && m_axis_tready;
        rd_nxt     = rd_en ? rd_ptr + ONE_P : rd_ptr;
        fill_after = wr_ptr + ONE_P - rd_nxt;
        // A non-final beat that fills the FIFO means the packet can never be committed
        go_drop    = (PACKET_MODE != 0) && wr_en && !s_axis_tlast && (fill_after == DEPTH_P);

        if (go_drop) begin
            wr_nxt = cm_ptr;
        end else if (wr_en) begin
            wr_nxt = wr_ptr + ONE_P;
        end else begin
            wr_nxt = wr_ptr;
        end

        if (PACKET_MODE == 0) begin
            cm_nxt = wr_nxt;
        end else if (wr_en && s_axis_tlast) begin
            cm_nxt = wr_ptr + ONE_P;
        end else begin
            cm_nxt = cm_ptr;
        end

        full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        cnt_nxt  = cm_nxt - rd_nxt;
        // Beat written this edge into the slot that becomes the head must bypass the RAM
        bypass   = wr_en && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]);
        head_nxt = bypass ? wr_ent : ram_rd;
    end

    // Pointers, registered outputs and write-side packet FSM
    always_ff @(posedge axis_clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            cm_ptr        <= '0;
            rd_ptr        <= '0;
            state         <= ST_IDLE;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            count         <= '0;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
            drop_pkt      <= 1'b0;
        end else begin
            wr_ptr        <= wr_nxt;
            cm_ptr        <= cm_nxt;
            rd_ptr        <= rd_nxt;
            s_axis_tready <= !full_nxt;
            m_axis_tvalid <= (cm_nxt != rd_nxt);
            {m_axis_tdata, m_axis_tkeep, m_axis_tlast} <= head_nxt;
            count         <= cnt_nxt;
            almost_full   <= (cnt_nxt >= AF_LVL);
            almost_empty  <= (cnt_nxt <= AE_LVL);
            drop_pkt      <= go_drop;

            if (PACKET_MODE != 0) begin
                case (state)
                    ST_IDLE, ST_RECV: begin
                        if (wr_en) begin
                            if (s_axis_tlast) begin
                                state <= ST_IDLE;
                            end else if (go_drop) begin
                                state <= ST_DROP;
                            end else begin
                                state <= ST_RECV;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench: cut-through instance (8-bit) and packet-mode instance (16-bit).
module tb_axis_pkt_fifo;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic       exp_ready;
        logic [4:0] exp_count;
        logic       exp_af;
        logic       exp_ae;
        logic       exp_mvalid;
    } fill_vec_t;

    logic clk;
    logic rst;

    logic        s0_valid, s0_ready, s0_last, m0_valid, m0_ready, m0_last;
    logic [7:0]  s0_data, m0_data;
    logic [0:0]  s0_keep, m0_keep;
    logic [4:0]  count0;
    logic        af0, ae0, drop0;

    logic        s1_valid, s1_ready, s1_last, m1_valid, m1_ready, m1_last;
    logic [15:0] s1_data, m1_data;
    logic [1:0]  s1_keep, m1_keep;
    logic [4:0]  count1;
    logic        af1, ae1, drop1;

    int n_checks = 0;
    int n_errors = 0;
    int n_drop   = 0;

    beat_t q0[$];
    beat_t q1[$];

    fill_vec_t fv[20];

    axis_pkt_fifo #(
        .DATA_W(8), .DEPTH(16), .PACKET_MODE(0), .AF_LEVEL(12), .AE_LEVEL(2)
    ) u_ct (
        .axis_clk(clk), .reset(rst),
        .s_axis_tvalid(s0_valid), .s_axis_tready(s0_ready), .s_axis_tdata(s0_data),
        .s_axis_tkeep(s0_keep), .s_axis_tlast(s0_last),
        .m_axis_tvalid(m0_valid), .m_axis_tready(m0_ready), .m_axis_tdata(m0_data),
        .m_axis_tkeep(m0_keep), .m_axis_tlast(m0_last),
        .count(count0), .almost_full(af0), .almost_empty(ae0), .drop_pkt(drop0)
    );

    axis_pkt_fifo #(
        .DATA_W(16), .DEPTH(16), .PACKET_MODE(1), .AF_LEVEL(12), .AE_LEVEL(2)
    ) u_pk (
        .axis_clk(clk), .reset(rst),
        .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready), .s_axis_tdata(s1_data),
        .s_axis_tkeep(s1_keep), .s_axis_tlast(s1_last),
        .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready), .m_axis_tdata(m1_data),
        .m_axis_tkeep(m1_keep), .m_axis_tlast(m1_last),
        .count(count1), .almost_full(af1), .almost_empty(ae1), .drop_pkt(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push1(input logic [15:0] d, input logic [1:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        q1.push_back(b);
    endtask

    // One clock: scoreboard handshakes seen before the edge, then advance to edge+1
    task automatic cyc();
        beat_t b;
        if (s0_valid && s0_ready) begin
            b.data = {8'h00, s0_data};
            b.keep = {1'b0, s0_keep};
            b.last = s0_last;
            q0.push_back(b);
        end
        if (m0_valid && m0_ready) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL m0_unexpected: got beat %0h, expected none", m0_data);
            end else begin
                b = q0.pop_front();
                chk("m0_data", 32'(m0_data), 32'(b.data));
                chk("m0_keep", 32'(m0_keep), 32'(b.keep));
                chk("m0_last", 32'(m0_last), 32'(b.last));
            end
        end
        if (m1_valid && m1_ready) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL m1_unexpected: got beat %0h, expected none", m1_data);
            end else begin
                b = q1.pop_front();
                chk("m1_data", 32'(m1_data), 32'(b.data));
                chk("m1_keep", 32'(m1_keep), 32'(b.keep));
                chk("m1_last", 32'(m1_last), 32'(b.last));
            end
        end
        @(posedge clk);
        #1;
        if (drop1) n_drop++;
    endtask

    task automatic drain0(input int budget);
        m0_ready = 1'b1;
        for (int i = 0; i < budget && q0.size() > 0; i++) cyc();
        chk("drain0_left", 32'(q0.size()), 32'd0);
        chk("drain0_mvalid", 32'(m0_valid), 32'd0);
        chk("drain0_count", 32'(count0), 32'd0);
        m0_ready = 1'b0;
    endtask

    task automatic drain1(input int budget);
        m1_ready = 1'b1;
        for (int i = 0; i < budget && q1.size() > 0; i++) cyc();
        chk("drain1_left", 32'(q1.size()), 32'd0);
        chk("drain1_mvalid", 32'(m1_valid), 32'd0);
        chk("drain1_count", 32'(count1), 32'd0);
        m1_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] k4 [5];
        k4[0] = 2'b11; k4[1] = 2'b01; k4[2] = 2'b10; k4[3] = 2'b11; k4[4] = 2'b01;

        for (int k = 0; k < 20; k++) begin
            fv[k].data       = 8'(k + 1);
            fv[k].exp_ready  = (k < 16);
            fv[k].exp_count  = (k < 16) ? 5'(k) : 5'd16;
            fv[k].exp_af     = (fv[k].exp_count >= 5'd12);
            fv[k].exp_ae     = (fv[k].exp_count <= 5'd2);
            fv[k].exp_mvalid = (k >= 1);
        end

        rst = 1'b1;
        s0_valid = 0; s0_data = '0; s0_keep = '0; s0_last = 0; m0_ready = 0;
        s1_valid = 0; s1_data = '0; s1_keep = '0; s1_last = 0; m1_ready = 0;

        // Reset values while reset is held
        repeat (5) @(posedge clk);
        #1;
        chk("rst_s0_ready", 32'(s0_ready), 32'd0);
        chk("rst_m0_valid", 32'(m0_valid), 32'd0);
        chk("rst_m0_data",  32'(m0_data),  32'd0);
        chk("rst_m0_keep",  32'(m0_keep),  32'd0);
        chk("rst_m0_last",  32'(m0_last),  32'd0);
        chk("rst_count0",   32'(count0),   32'd0);
        chk("rst_af0",      32'(af0),      32'd0);
        chk("rst_ae0",      32'(ae0),      32'd1);
        chk("rst_drop0",    32'(drop0),    32'd0);
        chk("rst_s1_ready", 32'(s1_ready), 32'd0);
        chk("rst_m1_valid", 32'(m1_valid), 32'd0);
        chk("rst_m1_data",  32'(m1_data),  32'd0);
        chk("rst_m1_keep",  32'(m1_keep),  32'd0);
        chk("rst_count1",   32'(count1),   32'd0);
        chk("rst_ae1",      32'(ae1),      32'd1);
        chk("rst_drop1",    32'(drop1),    32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_s0_ready", 32'(s0_ready), 32'd1);
        chk("post_rst_s1_ready", 32'(s1_ready), 32'd1);

        // Fill with reader stalled, table-driven
        for (int k = 0; k < 20; k++) begin
            s0_valid = 1'b1;
            s0_data  = fv[k].data;
            s0_keep  = 1'(k);
            s0_last  = (k % 4 == 3);
            chk("fill_ready",  32'(s0_ready), 32'(fv[k].exp_ready));
            chk("fill_count",  32'(count0),   32'(fv[k].exp_count));
            chk("fill_af",     32'(af0),      32'(fv[k].exp_af));
            chk("fill_ae",     32'(ae0),      32'(fv[k].exp_ae));
            chk("fill_mvalid", 32'(m0_valid), 32'(fv[k].exp_mvalid));
            cyc();
        end
        s0_valid = 1'b0;
        chk("full_count", 32'(count0), 32'd16);
        chk("full_ready", 32'(s0_ready), 32'd0);
        chk("full_head",  32'(m0_data), 32'h01);
        chk("full_q",     32'(q0.size()), 32'd16);
        drain0(40);
        chk("after_drain_ready", 32'(s0_ready), 32'd1);

        // Streaming with both sides always ready
        m0_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s0_valid = 1'b1;
            s0_data  = 8'($urandom);
            s0_keep  = 1'($urandom);
            s0_last  = 1'($urandom);
            if (i == 50 || i == 99) chk("stream_count", 32'(count0), 32'd1);
            cyc();
        end
        s0_valid = 1'b0;
        drain0(10);

        // Packet mode: 5-beat packet held until tlast is accepted
        for (int k = 0; k < 5; k++) begin
            s1_valid = 1'b1;
            s1_data  = 16'hA000 + 16'(k);
            s1_keep  = k4[k];
            s1_last  = (k == 4);
            push1(s1_data, s1_keep, s1_last);
            chk("pkt5_ready",  32'(s1_ready), 32'd1);
            chk("pkt5_mvalid", 32'(m1_valid), 32'd0);
            cyc();
        end
        s1_valid = 1'b0;
        chk("pkt5_commit_valid", 32'(m1_valid), 32'd1);
        chk("pkt5_count",        32'(count1),   32'd5);
        chk("pkt5_head_keep",    32'(m1_keep),  32'(2'b11));
        drain1(20);

        // Oversize 20-beat packet dropped, then a 3-beat packet passes
        n_drop = 0;
        for (int k = 0; k < 20; k++) begin
            s1_valid = 1'b1;
            s1_data  = 16'hB000 + 16'(k);
            s1_keep  = 2'b11;
            s1_last  = (k == 19);
            chk("big_ready",  32'(s1_ready), 32'd1);
            chk("big_mvalid", 32'(m1_valid), 32'd0);
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            s1_valid = 1'b1;
            s1_data  = 16'hC000 + 16'(k);
            s1_keep  = 2'(k + 1);
            s1_last  = (k == 2);
            push1(s1_data, s1_keep, s1_last);
            chk("small_ready", 32'(s1_ready), 32'd1);
            cyc();
        end
        s1_valid = 1'b0;
        chk("drop_pulses", 32'(n_drop), 32'd1);
        chk("small_count", 32'(count1), 32'd3);
        chk("small_valid", 32'(m1_valid), 32'd1);
        drain1(20);
        chk("drop_pulses_end", 32'(n_drop), 32'd1);

        // Reset in the middle of a packet
        n_drop = 0;
        for (int k = 0; k < 2; k++) begin
            s1_valid = 1'b1;
            s1_data  = 16'hD000 + 16'(k);
            s1_keep  = 2'b11;
            s1_last  = 1'b0;
            cyc();
        end
        s1_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_count",  32'(count1),   32'd0);
        chk("midrst_mvalid", 32'(m1_valid), 32'd0);
        chk("midrst_ready",  32'(s1_ready), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("midrst_ready_back", 32'(s1_ready), 32'd1);
        chk("midrst_no_drop",    32'(n_drop),   32'd0);
        for (int k = 0; k < 3; k++) begin
            s1_valid = 1'b1;
            s1_data  = 16'hE000 + 16'(k);
            s1_keep  = 2'b10;
            s1_last  = (k == 2);
            push1(s1_data, s1_keep, s1_last);
            cyc();
        end
        s1_valid = 1'b0;
        chk("clean_count", 32'(count1), 32'd3);
        drain1(20);
        chk("clean_no_drop", 32'(n_drop), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
